// File: rtl/swo_source_arbiter.sv
// Shares one byte channel between the Manchester (source 0) and UART (source 1) SWO decoders.
// Toggle-to-push conversion, per-source FIFOs, round-robin registered output, overflow/activity.
module swo_source_arbiter #(
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned IdleTimeout = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] src_enable_i,
  input  logic       manch_byte_avail_i,
  input  logic [7:0] manch_byte_i,
  input  logic       uart_byte_avail_i,
  input  logic [7:0] uart_byte_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_src_o,
  input  logic       clr_ovf_i,
  output logic [1:0] ovf_o,
  output logic [1:0] active_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FifoDepth);
  localparam logic [15:0] IdleTo = 16'(IdleTimeout);

  logic [1:0]      tog_in;
  logic [1:0][7:0] byte_in;
  logic [1:0]      tog_q;
  logic            primed_q;
  logic [1:0]      evt;
  logic [1:0]      pop;
  logic [1:0]      drop;
  logic [1:0]      nonempty;
  logic [1:0][7:0] head;

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_src_q, out_src_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] ovf_q, ovf_d;
  logic       load, grant;

  assign tog_in  = {uart_byte_avail_i, manch_byte_avail_i};
  assign byte_in = {uart_byte_i, manch_byte_i};

  // The first cycle after reset only samples the toggle levels.
  assign evt = primed_q ? (tog_in ^ tog_q) : 2'b00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tog_q    <= 2'b00;
      primed_q <= 1'b0;
    end else begin
      tog_q    <= tog_in;
      primed_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_src
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic [7:0]      mem_q [FifoDepth];
    logic [15:0]     act_cnt_q, act_cnt_d;
    logic            full, push, drop_s, hit;

    always_comb begin
      hit    = evt[i] & src_enable_i[i];
      full   = (cnt_q == FullCnt);
      push   = hit & (~full | pop[i]);
      drop_s = hit & full & ~pop[i];
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (!src_enable_i[i]) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end else begin
        if (push) wptr_d = wptr_q + PtrW'(1);
        if (pop[i]) rptr_d = rptr_q + PtrW'(1);
        case ({push, pop[i]})
          2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
          2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
          default: cnt_d = cnt_q;
        endcase
      end
      act_cnt_d = act_cnt_q;
      if (hit) act_cnt_d = '0;
      else if (act_cnt_q < IdleTo) act_cnt_d = act_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q    <= '0;
        rptr_q    <= '0;
        cnt_q     <= '0;
        act_cnt_q <= IdleTo;
      end else begin
        wptr_q    <= wptr_d;
        rptr_q    <= rptr_d;
        cnt_q     <= cnt_d;
        act_cnt_q <= act_cnt_d;
      end
    end

    // Storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= byte_in[i];
    end

    assign drop[i]     = drop_s;
    assign nonempty[i] = src_enable_i[i] & (cnt_q != '0);
    assign head[i]     = mem_q[rptr_q];
    assign active_o[i] = (act_cnt_q < IdleTo);
  end

  always_comb begin
    load         = ~out_valid_q | out_ready_i;
    grant        = (&nonempty) ? ~last_grant_q : nonempty[1];
    pop          = 2'b00;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (|nonempty) begin
        pop          = grant ? 2'b10 : 2'b01;
        out_valid_d  = 1'b1;
        out_data_d   = head[grant];
        out_src_d    = grant;
        last_grant_d = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // A drop in the same cycle as a clear must remain visible.
    ovf_d = (clr_ovf_i ? 2'b00 : ovf_q) | drop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      ovf_q        <= 2'b00;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_swo_source_arbiter.sv
// Scoreboard bench for swo_source_arbiter: directed stimulus queues expected {src,data};
// a negedge monitor pops and compares each accepted byte and checks stall stability.
module tb_swo_source_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic [1:0] src_enable_i = 2'b00;
  logic       manch_byte_avail_i = 1'b0;
  logic [7:0] manch_byte_i = 8'h00;
  logic       uart_byte_avail_i = 1'b0;
  logic [7:0] uart_byte_i = 8'h00;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] out_data_o;
  logic       out_src_o;
  logic       clr_ovf_i = 1'b0;
  logic [1:0] ovf_o;
  logic [1:0] active_o;

  swo_source_arbiter #(
    .FifoDepth  (4),
    .IdleTimeout(10)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .src_enable_i      (src_enable_i),
    .manch_byte_avail_i(manch_byte_avail_i),
    .manch_byte_i      (manch_byte_i),
    .uart_byte_avail_i (uart_byte_avail_i),
    .uart_byte_i       (uart_byte_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_data_o        (out_data_o),
    .out_src_o         (out_src_o),
    .clr_ovf_i         (clr_ovf_i),
    .ovf_o             (ovf_o),
    .active_o          (active_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_fail = 0;
  int n_deliv = 0;
  int n_valid_cycles = 0;
  logic [8:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_src = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    logic [8:0] e;
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid_o) n_valid_cycles++;
      if (stall_prev)
        check("stall_hold", {22'd0, out_valid_o, out_src_o, out_data_o},
              {22'd0, 1'b1, stall_src, stall_data});
      if (out_valid_o && out_ready_i) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_byte: got src=%0d data=%h, required no byte", out_src_o,
                   out_data_o);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {23'd0, out_src_o, out_data_o}, {23'd0, e});
        end
      end
      stall_prev = out_valid_o && !out_ready_i;
      stall_data = out_data_o;
      stall_src  = out_src_o;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input bit src, input logic [7:0] b, input bit expect_out);
    if (src == 1'b0) begin
      manch_byte_i       = b;
      manch_byte_avail_i = ~manch_byte_avail_i;
    end else begin
      uart_byte_i       = b;
      uart_byte_avail_i = ~uart_byte_avail_i;
    end
    if (expect_out) exp_q.push_back({src, b});
    cyc(1);
  endtask

  task automatic send_both(input logic [7:0] m, input logic [7:0] u);
    manch_byte_i       = m;
    manch_byte_avail_i = ~manch_byte_avail_i;
    uart_byte_i        = u;
    uart_byte_avail_i  = ~uart_byte_avail_i;
    cyc(1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    exp_q.delete();
    cyc(2);
    rst_ni = 1'b1;
    cyc(2);
  endtask

  int d0, v0;

  initial begin
    // Reset values
    #1 rst_ni = 1'b0;
    #20;
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_data", {24'd0, out_data_o}, 32'd0);
    check("rst_src", {31'd0, out_src_o}, 32'd0);
    check("rst_ovf", {30'd0, ovf_o}, 32'd0);
    check("rst_active", {30'd0, active_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cyc(2);

    // Single byte and activity timeout
    src_enable_i = 2'b01;
    out_ready_i  = 1'b1;
    v0 = n_valid_cycles;
    d0 = n_deliv;
    send(1'b0, 8'hA5, 1'b1);
    check("active_on", {30'd0, active_o}, 32'd1);
    cyc(9);
    check("active_hold", {30'd0, active_o}, 32'd1);
    cyc(1);
    check("active_off", {30'd0, active_o}, 32'd0);
    check("single_valid_cycles", n_valid_cycles - v0, 32'd1);
    check("single_deliv", n_deliv - d0, 32'd1);
    check("single_ovf", {30'd0, ovf_o}, 32'd0);

    // Round-robin with simultaneous events; lastGrant back at its reset value
    do_reset();
    src_enable_i = 2'b11;
    out_ready_i  = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h44});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h66});
    send_both(8'h11, 8'h44);
    send_both(8'h22, 8'h55);
    send_both(8'h33, 8'h66);
    cyc(10);
    check("rr_drained", exp_q.size(), 32'd0);

    // Overflow and clear priority
    do_reset();
    src_enable_i = 2'b01;
    out_ready_i  = 1'b0;
    for (int i = 1; i <= 6; i++) send(1'b0, 8'(i), i <= 5);
    check("ovf_set", {30'd0, ovf_o}, 32'd1);
    check("ovf_reg_byte", {23'd0, out_valid_o, out_data_o}, {23'd0, 1'b1, 8'h01});
    clr_ovf_i = 1'b1;
    send(1'b0, 8'h07, 1'b0);
    clr_ovf_i = 1'b0;
    check("ovf_clr_vs_drop", {30'd0, ovf_o}, 32'd1);
    clr_ovf_i = 1'b1;
    cyc(1);
    clr_ovf_i = 1'b0;
    check("ovf_cleared", {30'd0, ovf_o}, 32'd0);
    out_ready_i = 1'b1;
    cyc(8);
    check("ovf_drained", exp_q.size(), 32'd0);

    // Random backpressure, both sources
    src_enable_i = 2'b11;
    for (int i = 0; i < 12; i++) begin
      out_ready_i = 1'($urandom_range(0, 1));
      send(1'(i % 2), 8'h80 + 8'(i), 1'b1);
      for (int k = 0; k < 3; k++) begin
        out_ready_i = 1'($urandom_range(0, 1));
        cyc(1);
      end
    end
    out_ready_i = 1'b1;
    cyc(12);
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_no_ovf", {30'd0, ovf_o}, 32'd0);

    // Enable/flush: output register keeps its byte, queued bytes are discarded
    out_ready_i = 1'b0;
    d0 = n_deliv;
    send(1'b1, 8'hC1, 1'b1);
    send(1'b1, 8'hC2, 1'b0);
    send(1'b1, 8'hC3, 1'b0);
    send(1'b1, 8'hC4, 1'b0);
    src_enable_i = 2'b01;
    cyc(1);
    send(1'b1, 8'hC5, 1'b0);
    send(1'b1, 8'hC6, 1'b0);
    out_ready_i = 1'b1;
    cyc(4);
    src_enable_i = 2'b11;
    cyc(6);
    check("flush_deliv", n_deliv - d0, 32'd1);
    check("flush_valid", {31'd0, out_valid_o}, 32'd0);

    // Reset mid-stream, then priming with toggle input at 1
    src_enable_i = 2'b01;
    out_ready_i  = 1'b0;
    send(1'b0, 8'hD1, 1'b0);
    cyc(1);
    check("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("rst_async_valid", {31'd0, out_valid_o}, 32'd0);
    manch_byte_avail_i = 1'b1;
    cyc(2);
    out_ready_i = 1'b1;
    d0 = n_deliv;
    rst_ni = 1'b1;
    cyc(6);
    check("prime_no_event", n_deliv - d0, 32'd0);
    check("prime_valid", {31'd0, out_valid_o}, 32'd0);
    check("prime_active", {30'd0, active_o}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/swo_source_arbiter.md
# swo_source_arbiter

Scheduler that shares the single upstream byte channel between the two SWO byte decoders: source 0 is the Manchester decoder, source 1 is the NRZ/UART decoder. It converts each decoder's toggling byte-ready indicator into a push into a small per-source FIFO. It then round-robin arbitrates the FIFOs onto one registered valid/ready output toward the packet processor, and reports per-source overflow and link activity.

## Interface
- FIFO_DEPTH, 4: entries per source FIFO; a power of two, at least 2.
- IDLE_TIMEOUT, 16'd50000: number of clk cycles without a byte before a source is reported inactive; range 1..65535.

Ports:
- clk  in  1  module clock; same clock as both decoders.
- rst  in  1  one clock; reset is asynchronous and active-low.
- srcEnable  in  2  per-source enable; bit 0 = Manchester, bit 1 = UART.
- manchByteAvail  in  1  toggle indicator from the Manchester decoder.
- manchByte  in  8  byte from the Manchester decoder; stable whenever its toggle changes.
- uartByteAvail  in  1  toggle indicator from the UART decoder.
- uartByte  in  8  byte from the UART decoder.
- outValid  out  1  outData/outSrc hold a byte.
- outReady  in  1  downstream accepts the byte when outValid & outReady.
- outData  out  8  delivered byte.
- outSrc  out  1  source of outData (0 = Manchester, 1 = UART).
- clrOvf  in  1  single-cycle pulse that clears both overflow flags.
- ovf  out  2  sticky per-source flag: a byte was dropped because that source's FIFO was full.
- active  out  2  per-source flag: a byte arrived within the last IDLE_TIMEOUT cycles.

## Operation
- Edge detect:
  - Each source registers its previous toggle level.
  - A byte event occurs when the current toggle differs from the registered level.
  - In the first cycle after reset release, the registered level is loaded from the input and no event is generated (priming cycle).
- Enable:
  - Events from a disabled source are ignored, but its toggle level is still tracked.
  - When srcEnable[i] is low, FIFO i is held empty. A deassertion flushes FIFO i in the next cycle.
  - A byte already in the output register is not recalled.
- Push:
  - On an event from an enabled source, the byte is written to that source's FIFO.
  - The push succeeds if the FIFO is not full, or if it is full and is popped in the same cycle.
  - Otherwise the byte is dropped and ovf[i] is set.
- Overflow clear: clrOvf clears both ovf bits. A new overflow in the same cycle wins, so that bit reads 1.
- Output register:
  - Loads when outValid==0, or when outValid & outReady.
  - Loading pops one FIFO entry, chosen by the arbiter.
  - If no FIFO is non-empty when the register would otherwise drain, outValid goes to 0.
- Arbiter:
  - Round-robin on lastGrant.
  - If both FIFOs are non-empty, grant the source != lastGrant. Otherwise grant the only non-empty one.
  - lastGrant updates only on a grant. Its reset value is 1, so source 0 wins the first tie.
- Activity:
  - Per-source counter resets to 0 on each event from an enabled source.
  - Otherwise it increments, saturating at IDLE_TIMEOUT.
  - active[i] = (counter < IDLE_TIMEOUT). The counter resets to IDLE_TIMEOUT, so the source starts inactive.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - outputs: outValid=0, outData=0, outSrc=0, ovf=0, active=0.
  - internal: FIFOs empty, lastGrant=1.
- Latency: a toggle change seen at edge N pushes at edge N; outValid rises at edge N+1 if the output register is free. Minimum toggle-to-output latency is 1 cycle after the push.
- Throughput: one byte per cycle total while outReady stays high. Output is lossless while each source averages at most 1 byte per 2 cycles.
- outData/outSrc are stable while outValid & !outReady.
- Reset asserted mid-operation: all FIFO contents and flags are discarded immediately (asynchronous). The priming cycle repeats after release.
- Simultaneous events on both sources in the same cycle are both pushed, and both are delivered in round-robin order.

## Test plan
- Single byte: prime, enable 2'b01, toggle manchByteAvail with manchByte=8'hA5, outReady=1 → outValid for exactly 1 cycle, outData=8'hA5, outSrc=0, ovf=0.
- Round-robin: both sources enabled, inject 3 bytes each simultaneously (Manchester 11/22/33, UART 44/55/66), outReady=1 → output order 11,44,22,55,33,66 with outSrc alternating 0,1,0,1,0,1.
- Overflow: outReady=0, inject 6 Manchester bytes → the output register holds byte 1, the FIFO holds bytes 2-5, byte 6 is dropped, and ovf=2'b01. Pulse clrOvf in the same cycle as a further drop → ovf stays 2'b01.
- Backpressure stability: toggle outReady randomly → outData/outSrc are unchanged while stalled, and the full byte stream arrives in order with no duplicates.
- Enable/flush: fill the UART FIFO with 3 bytes, deassert srcEnable[1] → the FIFO is empty next cycle, further UART toggles are ignored, and re-enabling yields no spurious byte.
- Activity/reset: IDLE_TIMEOUT=10. One byte sets active[0]=1 on the next cycle; active[0] drops to 0 exactly 10 cycles after the last event. Assert rst mid-stream → outValid=0 immediately, and no event is generated in the priming cycle even if the toggle input is 1.
